// File: rtl/mem_io_responder.sv
// mem_io_responder: responder end of the CPU byte-wide memory bus.
// Holds the byte RAM (one-cycle read latency) and the I/O window at
// addr[17:16]==2'b11: UART TX/RX FIFOs, free-running cycle counter with a
// readable snapshot, and the sticky program-stop flag.
module mem_io_responder #(
    parameter int RAM_AW      = 17,
    parameter int TX_DEPTH    = 16,
    parameter int RX_DEPTH    = 16,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_stop,
    output logic        tx_overflow
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_PW = TX_AW + 1;
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_PW = RX_AW + 1;

    // Storage arrays (never reset)
    logic [7:0] ram    [0:(1 << RAM_AW) - 1];
    logic [7:0] tx_mem [0:TX_DEPTH - 1];
    logic [7:0] rx_mem [0:RX_DEPTH - 1];

    // Registered state
    logic [7:0]       cpu_din_q,  cpu_din_d;
    logic [TX_PW-1:0] tx_wr_q,    tx_wr_d;
    logic [TX_PW-1:0] tx_rd_q,    tx_rd_d;
    logic [RX_PW-1:0] rx_wr_q,    rx_wr_d;
    logic [RX_PW-1:0] rx_rd_q,    rx_rd_d;
    logic [31:0]      cnt_q,      cnt_d;
    logic [31:0]      snap_q,     snap_d;
    logic             iobf_q,     iobf_d;
    logic             stop_q,     stop_d;
    logic             ovf_q,      ovf_d;

    // Decode and FIFO control
    logic [1:0]       region;
    logic [15:0]      io_off;
    logic             ram_sel, io_sel;
    logic             ram_we;
    logic             io_rd_rx, io_wr_tx, io_wr_stop;
    logic             tx_push_req, tx_push, tx_pop, tx_full;
    logic [7:0]       tx_push_byte;
    logic [TX_PW-1:0] tx_count, tx_count_next;
    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^cpu_a[31:18];

    assign tx_count = tx_wr_q - tx_rd_q;
    assign tx_full  = (tx_count == TX_PW'(TX_DEPTH));
    assign tx_valid = (tx_wr_q != tx_rd_q);
    assign tx_data  = tx_mem[tx_rd_q[TX_AW-1:0]];

    assign rx_empty = (rx_wr_q == rx_rd_q);
    assign rx_full  = (rx_wr_q[RX_AW-1:0] == rx_rd_q[RX_AW-1:0]) &&
                      (rx_wr_q[RX_AW] != rx_rd_q[RX_AW]);
    assign rx_ready = !rx_full;

    assign cpu_din        = cpu_din_q;
    assign io_buffer_full = iobf_q;
    assign program_stop   = stop_q;
    assign tx_overflow    = ovf_q;

    // Address decode, FIFO pointer updates and read-data selection
    always_comb begin
        region       = cpu_a[17:16];
        io_off       = cpu_a[15:0];
        ram_sel      = !region[1];
        io_sel       = (region == 2'b11);
        ram_we       = ram_sel && cpu_wr;
        io_rd_rx     = io_sel && !cpu_wr && (io_off == 16'h0000);
        io_wr_tx     = io_sel &&  cpu_wr && (io_off == 16'h0000);
        io_wr_stop   = io_sel &&  cpu_wr && (io_off == 16'h0004);

        // A zero byte to the TX data port is a no-op; the stop write queues '\0'
        tx_push_req  = (io_wr_tx && (cpu_dout != 8'h00)) || io_wr_stop;
        tx_push_byte = io_wr_stop ? 8'h00 : cpu_dout;
        tx_pop       = tx_valid && tx_ready;
        // A pop in the same cycle frees the slot before the push lands
        tx_push      = tx_push_req && (!tx_full || tx_pop);
        tx_rd_d      = tx_rd_q + TX_PW'(tx_pop);
        tx_wr_d      = tx_wr_q + TX_PW'(tx_push);
        tx_count_next = tx_wr_d - tx_rd_d;
        iobf_d       = (tx_count_next >= TX_PW'(TX_DEPTH - FULL_MARGIN));
        ovf_d        = ovf_q || (tx_push_req && !tx_push);

        rx_push      = rx_valid && !rx_full;
        // An empty FIFO returns 0 even if a byte is arriving this cycle
        rx_pop       = io_rd_rx && !rx_empty;
        rx_wr_d      = rx_wr_q + RX_PW'(rx_push);
        rx_rd_d      = rx_rd_q + RX_PW'(rx_pop);

        cnt_d        = cnt_q + 32'd1;
        snap_d       = snap_q;
        stop_d       = stop_q || io_wr_stop;

        cpu_din_d    = 8'h00;
        if (ram_sel && !cpu_wr) begin
            cpu_din_d = ram[cpu_a[RAM_AW-1:0]];
        end else if (io_sel && !cpu_wr) begin
            case (io_off)
                16'h0000: cpu_din_d = rx_empty ? 8'h00 : rx_mem[rx_rd_q[RX_AW-1:0]];
                16'h0004: begin
                    snap_d    = cnt_q;
                    cpu_din_d = cnt_q[7:0];
                end
                16'h0005: cpu_din_d = snap_q[15:8];
                16'h0006: cpu_din_d = snap_q[23:16];
                16'h0007: cpu_din_d = snap_q[31:24];
                default:  cpu_din_d = 8'h00;
            endcase
        end
    end

    // Control and read-data registers with synchronous reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cpu_din_q <= 8'h00;
            tx_wr_q   <= '0;
            tx_rd_q   <= '0;
            rx_wr_q   <= '0;
            rx_rd_q   <= '0;
            cnt_q     <= 32'd0;
            snap_q    <= 32'd0;
            iobf_q    <= 1'b0;
            stop_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            cpu_din_q <= cpu_din_d;
            tx_wr_q   <= tx_wr_d;
            tx_rd_q   <= tx_rd_d;
            rx_wr_q   <= rx_wr_d;
            rx_rd_q   <= rx_rd_d;
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            iobf_q    <= iobf_d;
            stop_q    <= stop_d;
            ovf_q     <= ovf_d;
        end
    end

    // RAM and FIFO storage writes; contents survive reset
    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram[cpu_a[RAM_AW-1:0]] <= cpu_dout;
        end
        if (tx_push) begin
            tx_mem[tx_wr_q[TX_AW-1:0]] <= tx_push_byte;
        end
        if (rx_push) begin
            rx_mem[rx_wr_q[RX_AW-1:0]] <= rx_data;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: scoreboard queues hold expected
// read data and expected TX bytes.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        program_stop;
    logic        tx_overflow;

    int checks   = 0;
    int failures = 0;
    logic [7:0] rd_q[$];
    logic [7:0] tx_q[$];

    mem_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_wr(cpu_wr),
        .cpu_dout(cpu_dout), .cpu_din(cpu_din), .io_buffer_full(io_buffer_full),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .program_stop(program_stop), .tx_overflow(tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    // One bus cycle: drive the request, take the edge, sample 1 ns later
    task automatic cyc(input logic [31:0] a, input logic w, input logic [7:0] d);
        cpu_a = a; cpu_wr = w; cpu_dout = d;
        @(posedge clk_in); #1;
        cpu_a = 32'h0; cpu_wr = 1'b0; cpu_dout = 8'h00;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        @(posedge clk_in); @(posedge clk_in); #1;
        rst_in = 1'b0;
        rd_q.delete(); tx_q.delete();
    endtask

    task automatic test_reset();
        logic [7:0] e;
        do_reset();
        e = 8'h00; checks++;
        if (cpu_din !== e) begin failures++; $display("FAIL reset_cpu_din got=%h want=%h", cpu_din, e); end
        checks++;
        if ({tx_valid, rx_ready, io_buffer_full, program_stop, tx_overflow} !== 5'b01000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=01000", {tx_valid, rx_ready, io_buffer_full, program_stop, tx_overflow});
        end
    endtask

    task automatic test_ram();
        logic [31:0] addrs[6] = '{32'h00010, 32'h1FFFF, 32'h00100, 32'h00101, 32'h00102, 32'h0FFFF};
        logic [7:0]  vals[6]  = '{8'hA5, 8'h3C, 8'h01, 8'hFE, 8'h5A, 8'hC3};
        logic [7:0] e;
        for (int i = 0; i < 6; i++) cyc(addrs[i], 1'b1, vals[i]);
        // back-to-back pipelined reads, one byte per cycle
        for (int i = 0; i < 6; i++) begin
            rd_q.push_back(vals[i]);
            cyc(addrs[i], 1'b0, 8'h00);
            e = rd_q.pop_front(); checks++;
            if (cpu_din !== e) begin failures++; $display("FAIL ram_read a=%h got=%h want=%h", addrs[i], cpu_din, e); end
        end
    endtask

    task automatic test_unmapped();
        logic [7:0] e;
        cyc(32'h00004, 1'b1, 8'h55);
        cyc(32'h20004, 1'b1, 8'h77);
        rd_q.push_back(8'h00);
        cyc(32'h20004, 1'b0, 8'h00);
        e = rd_q.pop_front(); checks++;
        if (cpu_din !== e) begin failures++; $display("FAIL unmapped_read got=%h want=%h", cpu_din, e); end
        rd_q.push_back(8'h55);
        cyc(32'h00004, 1'b0, 8'h00);
        e = rd_q.pop_front(); checks++;
        if (cpu_din !== e) begin failures++; $display("FAIL unmapped_alias got=%h want=%h", cpu_din, e); end
    endtask

    task automatic test_tx();
        logic [7:0] msg[3] = '{8'h48, 8'h69, 8'h00};
        logic [7:0] e;
        int n;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(32'h30000, 1'b1, msg[i]);
            if (msg[i] != 8'h00) tx_q.push_back(msg[i]);
        end
        for (int i = 0; i < 11; i++) begin
            cyc(32'h30000, 1'b1, 8'(8'h20 + i));
            tx_q.push_back(8'(8'h20 + i));
        end
        checks++;
        if (io_buffer_full !== 1'b0) begin failures++; $display("FAIL tx_bf_at13 got=%b want=0", io_buffer_full); end
        cyc(32'h30000, 1'b1, 8'h2B);
        tx_q.push_back(8'h2B);
        checks++;
        if (io_buffer_full !== 1'b1) begin failures++; $display("FAIL tx_bf_at14 got=%b want=1", io_buffer_full); end
        tx_ready = 1'b1;
        n = 0;
        while (tx_valid && n < 40) begin
            checks++;
            e = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
            if (tx_data !== e) begin failures++; $display("FAIL tx_order idx=%0d got=%h want=%h", n, tx_data, e); end
            cyc(32'h0, 1'b0, 8'h00);
            n++;
        end
        tx_ready = 1'b0;
        checks++;
        if (n != 14 || tx_q.size() != 0) begin failures++; $display("FAIL tx_count got=%0d want=14", n); end
        checks++;
        if (io_buffer_full !== 1'b0) begin failures++; $display("FAIL tx_bf_drop got=%b want=0", io_buffer_full); end
    endtask

    task automatic test_overflow();
        logic [7:0] e;
        int n;
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cyc(32'h30000, 1'b1, 8'(8'h80 + i));
            tx_q.push_back(8'(8'h80 + i));
        end
        checks++;
        if (tx_overflow !== 1'b0) begin failures++; $display("FAIL ovf_at16 got=%b want=0", tx_overflow); end
        // push and pop together while full: both take effect
        tx_ready = 1'b1;
        e = tx_q.pop_front(); checks++;
        if (tx_data !== e) begin failures++; $display("FAIL ovf_pp_head got=%h want=%h", tx_data, e); end
        cyc(32'h30000, 1'b1, 8'h90);
        tx_q.push_back(8'h90);
        tx_ready = 1'b0;
        checks++;
        if (tx_overflow !== 1'b0) begin failures++; $display("FAIL ovf_pushpop got=%b want=0", tx_overflow); end
        cyc(32'h30000, 1'b1, 8'h91);
        checks++;
        if (tx_overflow !== 1'b1) begin failures++; $display("FAIL ovf_at17 got=%b want=1", tx_overflow); end
        tx_ready = 1'b1;
        n = 0;
        while (tx_valid && n < 40) begin
            checks++;
            e = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
            if (tx_data !== e) begin failures++; $display("FAIL ovf_order idx=%0d got=%h want=%h", n, tx_data, e); end
            cyc(32'h0, 1'b0, 8'h00);
            n++;
        end
        tx_ready = 1'b0;
        checks++;
        if (n != 16) begin failures++; $display("FAIL ovf_count got=%0d want=16", n); end
    endtask

    task automatic test_counter();
        logic [31:0] snap;
        logic [7:0] e;
        do_reset();
        for (int i = 0; i < 511; i++) cyc(32'h0, 1'b0, 8'h00);
        snap = 32'd511;
        for (int k = 0; k < 4; k++) begin
            rd_q.push_back(8'(snap >> (8 * k)));
            cyc(32'h30004 + k, 1'b0, 8'h00);
            e = rd_q.pop_front(); checks++;
            if (cpu_din !== e) begin failures++; $display("FAIL cnt_byte%0d got=%h want=%h", 4 + k, cpu_din, e); end
        end
        for (int i = 0; i < 10; i++) cyc(32'h0, 1'b0, 8'h00);
        rd_q.push_back(snap[15:8]);
        cyc(32'h30005, 1'b0, 8'h00);
        e = rd_q.pop_front(); checks++;
        if (cpu_din !== e) begin failures++; $display("FAIL cnt_reread got=%h want=%h", cpu_din, e); end
    endtask

    task automatic test_rx();
        logic [7:0] e;
        logic [7:0] exp_rd[$];
        // single push, then two reads
        rx_data = 8'h41; rx_valid = 1'b1; cyc(32'h0, 1'b0, 8'h00); rx_valid = 1'b0;
        exp_rd = '{8'h41, 8'h00};
        for (int i = 0; i < 2; i++) begin
            rd_q.push_back(exp_rd[i]);
            cyc(32'h30000, 1'b0, 8'h00);
            e = rd_q.pop_front(); checks++;
            if (cpu_din !== e) begin failures++; $display("FAIL rx_single%0d got=%h want=%h", i, cpu_din, e); end
        end
        // empty + push + pop in one cycle: returns 0, byte stays queued
        rx_data = 8'h5A; rx_valid = 1'b1;
        rd_q.push_back(8'h00);
        cyc(32'h30000, 1'b0, 8'h00);
        rx_valid = 1'b0;
        e = rd_q.pop_front(); checks++;
        if (cpu_din !== e) begin failures++; $display("FAIL rx_emptypp got=%h want=%h", cpu_din, e); end
        // push while popping a non-empty FIFO
        rx_data = 8'h22; rx_valid = 1'b1;
        rd_q.push_back(8'h5A);
        cyc(32'h30000, 1'b0, 8'h00);
        rx_valid = 1'b0;
        e = rd_q.pop_front(); checks++;
        if (cpu_din !== e) begin failures++; $display("FAIL rx_pushpop got=%h want=%h", cpu_din, e); end
        rd_q.push_back(8'h22);
        cyc(32'h30000, 1'b0, 8'h00);
        e = rd_q.pop_front(); checks++;
        if (cpu_din !== e) begin failures++; $display("FAIL rx_pushpop2 got=%h want=%h", cpu_din, e); end
        // fill, overfill, drain (wraps the pointers)
        rx_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            rx_data = 8'(8'h60 + i);
            if (i < 16) rd_q.push_back(8'(8'h60 + i));
            cyc(32'h0, 1'b0, 8'h00);
        end
        rx_valid = 1'b0;
        checks++;
        if (rx_ready !== 1'b0) begin failures++; $display("FAIL rx_full_ready got=%b want=0", rx_ready); end
        rd_q.push_back(8'h00);
        for (int i = 0; i < 17; i++) begin
            cyc(32'h30000, 1'b0, 8'h00);
            e = rd_q.pop_front(); checks++;
            if (cpu_din !== e) begin failures++; $display("FAIL rx_drain idx=%0d got=%h want=%h", i, cpu_din, e); end
        end
    endtask

    task automatic test_stop_reset();
        cyc(32'h30004, 1'b1, 8'h33);
        checks++;
        if (program_stop !== 1'b1) begin failures++; $display("FAIL stop_flag got=%b want=1", program_stop); end
        checks++;
        if ({tx_valid, tx_data} !== {1'b1, 8'h00}) begin
            failures++; $display("FAIL stop_nul got=%b/%h want=1/00", tx_valid, tx_data);
        end
        // reset with a RAM read in flight
        cyc(32'h00010, 1'b1, 8'hA5);
        rst_in = 1'b1;
        cyc(32'h00010, 1'b0, 8'h00);
        checks++;
        if (cpu_din !== 8'h00) begin failures++; $display("FAIL rst_inflight got=%h want=00", cpu_din); end
        cyc(32'h0, 1'b0, 8'h00);
        rst_in = 1'b0;
        checks++;
        if ({tx_valid, rx_ready, io_buffer_full, program_stop, tx_overflow} !== 5'b01000) begin
            failures++;
            $display("FAIL rst_flags got=%b want=01000", {tx_valid, rx_ready, io_buffer_full, program_stop, tx_overflow});
        end
    endtask

    initial begin
        rst_in = 1'b1; cpu_a = 32'h0; cpu_wr = 1'b0; cpu_dout = 8'h00;
        tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        test_reset();
        test_ram();
        test_unmapped();
        test_tx();
        test_overflow();
        test_counter();
        test_rx();
        test_stop_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
Responder end of the CPU byte-wide memory bus (address, write flag, data out, data in, io_buffer_full). It holds the 128 KB byte RAM with one-cycle read latency. It also decodes the I/O window at addr[17:16]==2'b11: UART TX/RX FIFOs, the cycle counter and the program-stop flag. The CPU top connects to it directly in simulation and FPGA builds.

Parameters:
RAM_AW, 17, RAM address width; depth 2**RAM_AW bytes
TX_DEPTH, 16, TX FIFO entries (power of 2)
RX_DEPTH, 16, RX FIFO entries (power of 2)
FULL_MARGIN, 2, io_buffer_full asserts when TX count >= TX_DEPTH-FULL_MARGIN

Ports:
clk_in  input  1  system clock; single clock domain
rst_in  input  1  synchronous, active-high reset
cpu_a  input  32  byte address from CPU; only [17:0] decoded
cpu_wr  input  1  1 = write, 0 = read
cpu_dout  input  8  write data from CPU
cpu_din  output  8  read data to CPU, valid the cycle after the request
io_buffer_full  output  1  TX FIFO near-full indication to CPU
tx_data  output  8  byte to UART transmitter
tx_valid  output  1  TX FIFO non-empty
tx_ready  input  1  UART accepts tx_data this cycle (pop)
rx_data  input  8  byte from UART receiver
rx_valid  input  1  push rx_data this cycle
rx_ready  output  1  RX FIFO not full
program_stop  output  1  sticky; set by a write to 0x30004
tx_overflow  output  1  sticky; a TX push was dropped while the FIFO was full

Behaviour:
- Reset (on a clk_in edge with rst_in=1) clears: cpu_din=0, both FIFOs emptied, tx_valid=0, rx_ready=1, io_buffer_full=0, program_stop=0, tx_overflow=0, cycle counter=0, counter snapshot=0. RAM contents are not cleared.
- Every cycle the bus presents a request; there is no idle encoding. A read of RAM address 0 is harmless.
- Address decode on cpu_a[17:16]: 00/01 = RAM at cpu_a[RAM_AW-1:0]; 10 = unmapped (reads return 0, writes ignored); 11 = I/O.
- RAM write: ram[addr] <= cpu_dout at the edge.
- RAM read: cpu_din <= ram[addr] at the edge. The data is seen by the CPU in the following cycle. Back-to-back reads are pipelined at 1 byte/cycle.
- cycle counter: 32 bits, increments every non-reset cycle, wraps at 2^32.
- I/O read 0x30000: cpu_din <= RX head and pops it. If the RX FIFO is empty, cpu_din <= 0 and nothing is popped.
- I/O read 0x30004: snapshot <= counter and cpu_din <= counter[7:0].
- I/O read 0x30005..0x30007: cpu_din <= snapshot[15:8], [23:16], [31:24]. The 4-byte dword is coherent if the CPU reads byte 4 first.
- Other I/O reads return 0.
- I/O write 0x30000: push cpu_dout into TX FIFO. A value of 0x00 is ignored (no push).
- I/O write 0x30004: set program_stop and push 0x00 into TX FIFO (terminating '\0').
- Other I/O writes are ignored.
- TX push when count==TX_DEPTH: byte dropped, tx_overflow set. A push and pop in the same cycle when full: the pop happens first, the push is accepted, count is unchanged.
- TX pop: occurs when tx_valid && tx_ready. tx_data is the FIFO head combinationally.
- io_buffer_full is registered from the next-state count: count_next >= TX_DEPTH-FULL_MARGIN.
- RX push: occurs when rx_valid && rx_ready. rx_valid while full drops the byte.
- RX push and CPU pop in the same cycle: both take effect.
- RX empty and push in the same cycle as a CPU pop: the pop returns 0 and the byte remains queued.
- FIFO pointers are log2(depth)+1 bits with wrap-bit full/empty detection. Wrap-around is seamless.
- Reset mid-stream: FIFO contents are discarded, and the cpu_din of the in-flight read becomes 0.

Test Plan:
- RAM: write 0xA5 to 0x00010, then read 0x00010 -> cpu_din==0xA5 one cycle after the read. Read 0x1FFFF after writing 0x3C there -> 0x3C.
- Unmapped: write 0x77 to 0x20004, then read 0x20004 -> cpu_din==0x00; RAM[0x00004] is unchanged.
- TX: tx_ready=0; write 'H','i',0x00 to 0x30000 -> exactly 2 entries queued. Fill to 14 -> io_buffer_full==1. Raise tx_ready -> bytes 'H','i' emerge in order and io_buffer_full drops.
- TX overflow: with tx_ready=0, perform 17 non-zero writes -> 16 queued, tx_overflow==1, and the 17th byte is absent.
- Counter: after 100 cycles post-reset, read 0x30004..0x30007 -> the bytes form the snapshot value (within 1 cycle of 100). Reading 0x30005 again later returns the same byte.
- RX / stop: push 0x41 via rx_valid, then read 0x30000 twice -> 0x41 then 0x00. Write 0x30004 -> program_stop==1 and 0x00 appears on tx_data. Apply rst_in -> all outputs return to their reset values.
